hack_ram_loader: RTL and testbench



---
 rtl/hack_ram_loader.sv | 159 +++++++++++++++
 tb/tb_hack_ram_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_ram_loader.sv
// Byte-stream to 16-bit RAM preload engine. It assembles big-endian words from a valid/ready
// stream and writes them at consecutive addresses; define HACK_RAM_LOADER_CHECKSUM_EN for a trailing checksum.
module hack_ram_loader #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned WORD_COUNT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] ram_in,
  output logic [13:0] ram_address,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic [14:0] words_written,
  output logic        checksum_ok
);

  localparam logic [13:0] BASE  = 14'(BASE_ADDR);
  localparam logic [14:0] COUNT = 15'(WORD_COUNT);

`ifdef HACK_RAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CK_HI, S_CK_LO, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_DONE
  } state_t;
`endif

  state_t      state, state_next;
  logic [7:0]  hi_byte;
  logic [15:0] word_q;
  logic [13:0] ptr;
  logic [14:0] ww_q;
  logic [14:0] ww_inc;
  logic        accept;
  logic        start_ok;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign ww_inc    = ww_q + 15'd1;
  assign last_word = !(ww_inc < COUNT);

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start_ok) state_next = S_HI;
      S_HI:           if (accept)   state_next = S_LO;
      S_LO:           if (accept)   state_next = S_WRITE;
      S_WRITE: begin
        if (!last_word) begin
          state_next = S_HI;
        end else begin
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
          state_next = S_CK_HI;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      S_CK_HI:        if (accept)   state_next = S_CK_LO;
      S_CK_LO:        if (accept)   state_next = S_DONE;
`endif
      default:        state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    ram_load   = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_HI, S_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        ram_load = 1'b1;
        busy     = 1'b1;
      end
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
      S_CK_HI, S_CK_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // The high byte waits in hi_byte so that ram_in only ever shows complete words.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi_byte <= '0;
      word_q  <= '0;
      ptr     <= BASE;
      ww_q    <= '0;
    end else begin
      if (start_ok) begin
        ptr  <= BASE;
        ww_q <= '0;
      end
      if (state == S_HI && accept) hi_byte <= byte_in;
      if (state == S_LO && accept) word_q  <= {hi_byte, byte_in};
      if (state == S_WRITE) begin
        ptr  <= ptr + 14'd1;
        ww_q <= ww_inc;
      end
    end
  end

`ifdef HACK_RAM_LOADER_CHECKSUM_EN
  logic [15:0] acc;
  logic [7:0]  ck_hi;
  logic        ck_ok;

  // The accumulator wraps mod 2^16; the verdict is captured on the edge that accepts the low checksum byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc   <= '0;
      ck_hi <= '0;
      ck_ok <= 1'b0;
    end else begin
      if (start_ok) begin
        acc   <= '0;
        ck_ok <= 1'b0;
      end
      if (state == S_WRITE)           acc   <= acc + word_q;
      if (state == S_CK_HI && accept) ck_hi <= byte_in;
      if (state == S_CK_LO && accept) ck_ok <= ({ck_hi, byte_in} == acc);
    end
  end

  assign checksum_ok = ck_ok;
`else
  assign checksum_ok = done;
`endif

  assign ram_in        = word_q;
  assign ram_address   = ptr;
  assign words_written = ww_q;

endmodule

// File: tb/tb_hack_ram_loader.sv
// Self-checking bench for hack_ram_loader: two instances cover a plain window (base 100, 2 words)
// and a wrapping window (base 16383, 3 words). A write-queue model is checked on every cycle.
module tb_hack_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sel;

  always #5 clk = ~clk;

  logic        rdy_a, load_a, busy_a, done_a, ok_a;
  logic [15:0] in_a;
  logic [13:0] addr_a;
  logic [14:0] ww_a;
  logic        rdy_b, load_b, busy_b, done_b, ok_b;
  logic [15:0] in_b;
  logic [13:0] addr_b;
  logic [14:0] ww_b;

  hack_ram_loader #(.BASE_ADDR(100), .WORD_COUNT(2)) dut_a (
    .CLK(clk), .RST_N(rst_n), .start(start && !sel), .byte_in(byte_in),
    .byte_valid(byte_valid && !sel), .byte_ready(rdy_a), .ram_in(in_a),
    .ram_address(addr_a), .ram_load(load_a), .busy(busy_a), .done(done_a),
    .words_written(ww_a), .checksum_ok(ok_a)
  );

  hack_ram_loader #(.BASE_ADDR(16383), .WORD_COUNT(3)) dut_b (
    .CLK(clk), .RST_N(rst_n), .start(start && sel), .byte_in(byte_in),
    .byte_valid(byte_valid && sel), .byte_ready(rdy_b), .ram_in(in_b),
    .ram_address(addr_b), .ram_load(load_b), .busy(busy_b), .done(done_b),
    .words_written(ww_b), .checksum_ok(ok_b)
  );

  logic        obs_ready, obs_load, obs_busy, obs_done, obs_ok;
  logic [15:0] obs_in;
  logic [13:0] obs_addr;
  logic [14:0] obs_ww;
  int          cur_base, cur_count;

  assign obs_ready = sel ? rdy_b  : rdy_a;
  assign obs_load  = sel ? load_b : load_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_ok    = sel ? ok_b   : ok_a;
  assign obs_in    = sel ? in_b   : in_a;
  assign obs_addr  = sel ? addr_b : addr_a;
  assign obs_ww    = sel ? ww_b   : ww_a;
  assign cur_base  = sel ? 16383  : 100;
  assign cur_count = sel ? 3      : 2;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
    int          idx;
    int          edge_n;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:16383];
  logic [15:0] sum_model;
  int          word_idx;
  int          n_writes = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // The bench is the RAM: it captures whatever the loader strobes.
  always @(posedge clk) if (obs_load) mem[obs_addr] <= obs_in;

  always @(negedge clk) begin
    wr_t e;
    check("addr_tracks_count", 32'(obs_addr), 32'((cur_base + int'(obs_ww)) % 16384));
    check("exclusive_flags",
          32'({obs_load && obs_ready, (obs_load || obs_ready) && !obs_busy, obs_busy && obs_done}),
          32'(0));
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    check("ok_only_in_done", 32'(obs_ok && !obs_done), 32'(0));
`else
    check("ok_equals_done", 32'(obs_ok), 32'(obs_done));
`endif
    if (obs_load) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(obs_addr), 32'(e.addr));
        check("write_data", 32'(obs_in), 32'(e.data));
        check("write_count", 32'(obs_ww), 32'(e.idx));
        check("write_cycle", 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, output int edge_n);
    int w = 0;
    if (stall) begin
      int n = int'($urandom_range(0, 3));
      repeat (n) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        tick();
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!obs_ready && w < 100) begin
      tick();
      w++;
    end
    if (!obs_ready) begin
      check("byte_wait_timeout", 32'(0), 32'(1));
      byte_valid = 1'b0;
      edge_n     = -1;
    end else begin
      tick();
      edge_n     = cyc;
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit stall);
    int  e_hi, e_lo;
    wr_t e;
    logic [7:0] hb, lb;
    hb = w[15:8];
    lb = w[7:0];
    send_byte(hb, stall, e_hi);
    send_byte(lb, stall, e_lo);
    e.addr   = 14'((cur_base + word_idx) % 16384);
    e.data   = w;
    e.idx    = word_idx;
    e.edge_n = e_lo;
    exp_q.push_back(e);
    sum_model = sum_model + w;
    word_idx++;
    if (!stall) check("lo_right_after_hi", 32'(e_lo), 32'(e_hi + 1));
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    word_idx  = 0;
    sum_model = 16'h0000;
    check("ready_after_start", 32'(obs_ready), 32'(1));
    check("count_cleared", 32'(obs_ww), 32'(0));
    check("ok_cleared", 32'(obs_ok), 32'(0));
    check("busy_after_start", 32'(obs_busy), 32'(1));
  endtask

  task automatic end_session(input logic [15:0] ck, input bit stall);
    logic exp_ok;
`ifdef HACK_RAM_LOADER_CHECKSUM_EN
    int e0, e1;
    logic [7:0] hb, lb;
    hb = ck[15:8];
    lb = ck[7:0];
    send_byte(hb, stall, e0);
    send_byte(lb, stall, e1);
    exp_ok = (ck == sum_model);
`else
    tick();
    exp_ok = 1'b1;
`endif
    check("done_on_time", 32'(obs_done), 32'(1));
    check("done_not_busy", 32'(obs_busy), 32'(0));
    check("final_count", 32'(obs_ww), 32'(cur_count));
    check("checksum_ok", 32'(obs_ok), 32'(exp_ok));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_values();
    check("rst_ready", 32'(obs_ready), 32'(0));
    check("rst_load", 32'(obs_load), 32'(0));
    check("rst_busy", 32'(obs_busy), 32'(0));
    check("rst_done", 32'(obs_done), 32'(0));
    check("rst_ok", 32'(obs_ok), 32'(0));
    check("rst_ram_in", 32'(obs_in), 32'(0));
    check("rst_addr", 32'(obs_addr), 32'(cur_base));
    check("rst_count", 32'(obs_ww), 32'(0));
  endtask

  initial begin
    int w0;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sel        = 1'b0;

    // Reset, then idle without start: nothing may be accepted.
    repeat (3) tick();
    check_reset_values();
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    repeat (3) tick();
    check("idle_no_ready", 32'(obs_ready), 32'(0));
    check("idle_no_busy", 32'(obs_busy), 32'(0));
    byte_valid = 1'b0;

    // Basic load at base 100.
    w0 = n_writes;
    start_session();
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    end_session(16'hBE01, 1'b0);
    check("sum_pin_basic", 32'(sum_model), 32'(16'hBE01));
    check("ram100_basic", 32'(mem[100]), 32'(16'h1234));
    check("ram101_basic", 32'(mem[101]), 32'(16'hABCD));
    check("two_pulses", 32'(n_writes - w0), 32'(2));
    check("ram_in_holds", 32'(obs_in), 32'(16'hABCD));

    // Stalled stream plus a start pulse mid-session that must be ignored.
    start_session();
    send_word(16'h5AA5, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_busy", 32'(obs_ww), 32'(1));
    send_word(16'h0F0F, 1'b1);
    end_session(16'h69B4, 1'b1);
    check("ram100_stall", 32'(mem[100]), 32'(16'h5AA5));
    check("ram101_stall", 32'(mem[101]), 32'(16'h0F0F));

    // Checksum match, then mismatch; RAM is written either way.
    start_session();
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0002, 1'b0);
    check("sum_pin_wrap16", 32'(sum_model), 32'(16'h0001));
    end_session(16'h0001, 1'b0);
    start_session();
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0002, 1'b0);
    end_session(16'h0002, 1'b0);
    check("ram100_ck", 32'(mem[100]), 32'(16'hFFFF));
    check("ram101_ck", 32'(mem[101]), 32'(16'h0002));

    // Address wrap on the base-16383 instance.
    sel = 1'b1;
    tick();
    start_session();
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    send_word(16'h0003, 1'b0);
    end_session(16'h0006, 1'b0);
    check("ram16383_wrap", 32'(mem[16383]), 32'(16'h0001));
    check("ram0_wrap", 32'(mem[0]), 32'(16'h0002));
    check("ram1_wrap", 32'(mem[1]), 32'(16'h0003));
    check("addr_after_wrap", 32'(obs_addr), 32'(2));

    // Reset after the high byte of word 3: no third write, clean restart.
    w0 = n_writes;
    start_session();
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_byte(8'h33, 1'b0, w0);
    w0 = n_writes;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (4) tick();
    check("no_partial_write", 32'(n_writes - w0), 32'(0));
    check("ram1_untouched", 32'(mem[1]), 32'(16'h0003));
    check("queue_after_reset", 32'(exp_q.size()), 32'(0));
    rst_n = 1'b1;
    tick();
    start_session();
    check("restart_addr", 32'(obs_addr), 32'(16383));
    send_word(16'h4444, 1'b1);
    send_word(16'h5555, 1'b1);
    send_word(16'h6666, 1'b1);
    end_session(16'hFFFF, 1'b1);
    check("ram16383_restart", 32'(mem[16383]), 32'(16'h4444));
    check("ram0_restart", 32'(mem[0]), 32'(16'h5555));
    check("ram1_restart", 32'(mem[1]), 32'(16'h6666));

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
